pong_game: RTL and testbench

Per-frame game-state engine for the Pong design. Sits directly upstream of the pixel renderer and drives its paddle/ball position inputs. Takes the raster position from the VGA timing generator and the player buttons, and advances paddles, ball, collisions and score once per frame during vertical blanking. All position outputs are registered and change only during blanking, so every active frame is drawn from stable values.

---
 rtl/pong_pkg.sv | 53 +++++
 rtl/pong_game_if.sv | 30 +++
 rtl/pong_game_button_sync.sv | 32 +++
 rtl/pong_game.sv | 169 ++++++++++++++++
 tb/tb_pong_game.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Pong shared definitions: screen geometry (all sizes are half-sizes),
// derived collision/rebound coordinates, the game state encoding and small
// arithmetic helpers. Imported by the game engine and by the pixel renderer.
package pong_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PADDLE1X = 20;
  localparam int PADDLE2X = 620;
  localparam int PADDLE_W = 5;
  localparam int PADDLE_H = 25;
  localparam int BALL_W   = 5;
  localparam int BALL_H   = 5;

  localparam int PADDLE_Y_MIN = 26;
  localparam int PADDLE_Y_MAX = 453;
  localparam int CENTRE_X     = 320;
  localparam int CENTRE_Y     = 240;

  // Paddle faces (ball-facing edge) and backs, horizontal.
  localparam int L_FACE    = PADDLE1X + PADDLE_W;   // 25
  localparam int L_BACK    = PADDLE1X - PADDLE_W;   // 15
  localparam int R_FACE    = PADDLE2X - PADDLE_W;   // 615
  localparam int R_BACK    = PADDLE2X + PADDLE_W;   // 625
  // Centre-to-centre distance below which the ball overlaps a paddle.
  localparam int HIT_RANGE = PADDLE_H + BALL_H;     // 30
  // Ball centre positions after a rebound.
  localparam int L_REBOUND   = L_FACE + BALL_W;     // 30
  localparam int R_REBOUND   = R_FACE - BALL_W;     // 610
  localparam int BOTTOM_EDGE = SCREEN_H - 1;        // 479
  localparam int RIGHT_EDGE  = SCREEN_W - 1;        // 639
  localparam int TOP_REBOUND = BALL_H + 1;          // 6
  localparam int BOT_REBOUND = BOTTOM_EDGE - BALL_H - 1; // 473

  typedef enum logic [1:0] {SERVE, PLAY, GAME_OVER} game_state_t;

  function automatic int abs_int(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // One frame of paddle motion: opposing buttons cancel, result is clamped.
  function automatic int step_paddle(input int y, input logic up,
                                     input logic dn, input int speed);
    int n;
    n = y;
    if (up && !dn)      n = y - speed;
    else if (dn && !up) n = y + speed;
    if (n < PADDLE_Y_MIN)      n = PADDLE_Y_MIN;
    else if (n > PADDLE_Y_MAX) n = PADDLE_Y_MAX;
    return n;
  endfunction

endpackage

// File: rtl/pong_game_if.sv
// Bundle between the game engine and its surroundings: raster position and
// player buttons in, paddle/ball positions, scores and game-over flag out.
//   master : the game engine (consumes raster/buttons, drives game state)
//   slave  : timing generator / buttons / renderer side
interface pong_game_if;
  logic signed [31:0] XPOS;
  logic signed [31:0] YPOS;
  logic               P1_UP;
  logic               P1_DOWN;
  logic               P2_UP;
  logic               P2_DOWN;
  logic               START;
  logic signed [31:0] PADDLE1Y;
  logic signed [31:0] PADDLE2Y;
  logic signed [31:0] BALLX;
  logic signed [31:0] BALLY;
  logic [3:0]         SCORE1;
  logic [3:0]         SCORE2;
  logic               GAME_OVER;

  modport master (
    input  XPOS, YPOS, P1_UP, P1_DOWN, P2_UP, P2_DOWN, START,
    output PADDLE1Y, PADDLE2Y, BALLX, BALLY, SCORE1, SCORE2, GAME_OVER
  );

  modport slave (
    output XPOS, YPOS, P1_UP, P1_DOWN, P2_UP, P2_DOWN, START,
    input  PADDLE1Y, PADDLE2Y, BALLX, BALLY, SCORE1, SCORE2, GAME_OVER
  );
endinterface

// File: rtl/pong_game_button_sync.sv
// button_sync: WIDTH-bit two-flop synchronizer for asynchronous levels.
//   clk : sampling clock
//   rst : synchronous active-high reset, clears both stages to 0
//   d   : asynchronous inputs
//   q   : synchronized outputs, two clk cycles of latency
module button_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking so the second stage takes the first stage's pre-edge
  // value; blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pong_game.sv
// pong_game: per-frame game-state engine. Once per frame, on the raster
// position (0,480) inside vertical blanking, it advances paddles, ball,
// collisions and score. All outputs come straight from flops.
//   VGA_CLOCK : pixel clock
//   RESET     : synchronous active-high reset
//   bus       : pong_game_if master (raster + buttons in, game state out)
module pong_game
  import pong_pkg::*;
#(
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input logic         VGA_CLOCK,
  input logic         RESET,
  pong_game_if.master bus
);

  logic [4:0] btn_raw, btn_s;
  logic       p1_up, p1_dn, p2_up, p2_dn, start;
  logic       tick;

  game_state_t state_q, state_d;
  logic [31:0] serve_cnt_q, serve_cnt_d;
  int          p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  int          ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  int          dx_q, dx_d, dy_q, dy_d;
  logic [3:0]  score1_q, score1_d, score2_q, score2_d;
  int          nx, ny;
  logic        won;

  assign btn_raw = {bus.P1_UP, bus.P1_DOWN, bus.P2_UP, bus.P2_DOWN, bus.START};

  button_sync #(.WIDTH(5)) u_button_sync (
    .clk (VGA_CLOCK),
    .rst (RESET),
    .d   (btn_raw),
    .q   (btn_s)
  );

  assign {p1_up, p1_dn, p2_up, p2_dn, start} = btn_s;
  assign tick = (bus.XPOS == 0) && (bus.YPOS == SCREEN_H);

  // NOTE: every variable gets its hold value first, so no branch leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    p1_y_d      = p1_y_q;
    p2_y_d      = p2_y_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    nx          = ball_x_q + dx_q;
    ny          = ball_y_q + dy_q;
    won         = 1'b0;

    if (tick) begin
      if (state_q != GAME_OVER) begin
        p1_y_d = step_paddle(p1_y_q, p1_up, p1_dn, PADDLE_SPEED);
        p2_y_d = step_paddle(p2_y_q, p2_up, p2_dn, PADDLE_SPEED);
      end

      unique case (state_q)
        SERVE: begin
          ball_x_d = CENTRE_X;
          ball_y_d = CENTRE_Y;
          if (serve_cnt_q + 32'd1 == 32'(SERVE_FRAMES)) begin
            serve_cnt_d = '0;
            state_d     = PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + 32'd1;
          end
        end

        PLAY: begin
          // Each rule below may override what an earlier one produced; a
          // wall and a paddle reflection touch different axes, so both apply.
          ball_x_d = nx;
          ball_y_d = ny;
          if (ny - BALL_H <= 0) begin
            ball_y_d = TOP_REBOUND;
            dy_d     = BALL_SPEED;
          end else if (ny + BALL_H >= BOTTOM_EDGE) begin
            ball_y_d = BOT_REBOUND;
            dy_d     = -BALL_SPEED;
          end
          if (dx_q < 0 && nx - BALL_W <= L_FACE && nx - BALL_W > L_BACK &&
              abs_int(ny - p1_y_q) < HIT_RANGE) begin
            ball_x_d = L_REBOUND;
            dx_d     = BALL_SPEED;
          end
          if (dx_q > 0 && nx + BALL_W >= R_FACE && nx + BALL_W < R_BACK &&
              abs_int(ny - p2_y_q) < HIT_RANGE) begin
            ball_x_d = R_REBOUND;
            dx_d     = -BALL_SPEED;
          end
          // A miss discards any wall reflection computed above.
          if (nx - BALL_W <= 0 || nx + BALL_W >= RIGHT_EDGE) begin
            ball_x_d = CENTRE_X;
            ball_y_d = CENTRE_Y;
            dy_d     = dy_q;
            if (nx - BALL_W <= 0) begin
              score2_d = score2_q + 4'd1;
              dx_d     = -BALL_SPEED;
              won      = (score2_q + 4'd1 == 4'(WIN_SCORE));
            end else begin
              score1_d = score1_q + 4'd1;
              dx_d     = BALL_SPEED;
              won      = (score1_q + 4'd1 == 4'(WIN_SCORE));
            end
            state_d = won ? GAME_OVER : SERVE;
          end
        end

        GAME_OVER: begin
          ball_x_d = CENTRE_X;
          ball_y_d = CENTRE_Y;
          if (start) begin
            score1_d = '0;
            score2_d = '0;
            state_d  = SERVE;
          end
        end

        default: state_d = SERVE;
      endcase
    end
  end

  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      state_q     <= SERVE;
      serve_cnt_q <= '0;
      p1_y_q      <= CENTRE_Y;
      p2_y_q      <= CENTRE_Y;
      ball_x_q    <= CENTRE_X;
      ball_y_q    <= CENTRE_Y;
      dx_q        <= BALL_SPEED;
      dy_q        <= BALL_SPEED;
      score1_q    <= '0;
      score2_q    <= '0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      p1_y_q      <= p1_y_d;
      p2_y_q      <= p2_y_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
    end
  end

  assign bus.PADDLE1Y  = p1_y_q;
  assign bus.PADDLE2Y  = p2_y_q;
  assign bus.BALLX     = ball_x_q;
  assign bus.BALLY     = ball_y_q;
  assign bus.SCORE1    = score1_q;
  assign bus.SCORE2    = score2_q;
  assign bus.GAME_OVER = (state_q == GAME_OVER);

endmodule

// File: tb/tb_pong_game.sv
// Directed bench for pong_game: a vector table for the first rally (serve,
// paddle clamp, walls, right-paddle rebound), then hand-written sequences
// for mid-play reset, nine right-side misses, game-over freeze and restart.
module tb_pong_game;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pong_game_if pif ();

  pong_game dut (
    .VGA_CLOCK (clk),
    .RESET     (rst),
    .bus       (pif)
  );

  typedef struct {
    int         n;      // ticks to run before comparing
    logic [4:0] btn;    // {p1_up, p1_down, p2_up, p2_down, start}
    int         p1, p2, bx, by, s1, s2, go;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int p1, input int p2,
                           input int bx, input int by, input int s1,
                           input int s2, input int go);
    check({tag, ".p1"}, pif.PADDLE1Y, p1);
    check({tag, ".p2"}, pif.PADDLE2Y, p2);
    check({tag, ".bx"}, pif.BALLX, bx);
    check({tag, ".by"}, pif.BALLY, by);
    check({tag, ".s1"}, 32'(pif.SCORE1), s1);
    check({tag, ".s2"}, 32'(pif.SCORE2), s2);
    check({tag, ".go"}, 32'(pif.GAME_OVER), go);
  endtask

  task automatic set_btn(input logic [4:0] b);
    {pif.P1_UP, pif.P1_DOWN, pif.P2_UP, pif.P2_DOWN, pif.START} = b;
  endtask

  // Two idle cycles let button changes through the synchronizer, then a
  // one-cycle tick; returns at the following negedge for sampling.
  task automatic do_tick();
    repeat (2) @(negedge clk);
    pif.XPOS = 0;
    pif.YPOS = 480;
    @(negedge clk);
    pif.XPOS = 1;
    pif.YPOS = 0;
  endtask

  initial begin
    //          n    btn       p1   p2   bx   by  s1 s2 go
    vecs[0]  = '{0,   5'b00000, 240, 240, 320, 240, 0, 0, 0};
    vecs[1]  = '{1,   5'b10010, 236, 244, 320, 240, 0, 0, 0};
    vecs[2]  = '{44,  5'b10010, 60,  420, 320, 240, 0, 0, 0};
    vecs[3]  = '{8,   5'b10000, 28,  420, 320, 240, 0, 0, 0};
    vecs[4]  = '{1,   5'b10000, 26,  420, 320, 240, 0, 0, 0};
    vecs[5]  = '{6,   5'b10000, 26,  420, 320, 240, 0, 0, 0};
    vecs[6]  = '{1,   5'b10000, 26,  420, 322, 242, 0, 0, 0};
    vecs[7]  = '{115, 5'b11110, 26,  420, 552, 472, 0, 0, 0};
    vecs[8]  = '{1,   5'b11110, 26,  420, 554, 473, 0, 0, 0};
    vecs[9]  = '{1,   5'b11110, 26,  420, 556, 471, 0, 0, 0};
    vecs[10] = '{26,  5'b11110, 26,  420, 608, 419, 0, 0, 0};
    vecs[11] = '{1,   5'b11110, 26,  420, 610, 417, 0, 0, 0};
    vecs[12] = '{1,   5'b11110, 26,  420, 608, 415, 0, 0, 0};
    vecs[13] = '{204, 5'b11110, 26,  420, 200, 7,   0, 0, 0};
    vecs[14] = '{1,   5'b11110, 26,  420, 198, 6,   0, 0, 0};
    vecs[15] = '{1,   5'b11110, 26,  420, 196, 8,   0, 0, 0};

    rst = 1'b1;
    pif.XPOS = 1;
    pif.YPOS = 0;
    set_btn(5'b00000);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // First rally from reset, table-driven.
    for (int i = 0; i < 16; i++) begin
      set_btn(vecs[i].btn);
      for (int k = 0; k < vecs[i].n; k++) do_tick();
      check_all($sformatf("v%0d", i), vecs[i].p1, vecs[i].p2, vecs[i].bx,
                vecs[i].by, vecs[i].s1, vecs[i].s2, vecs[i].go);
    end

    // Reset coincident with a tick in the middle of play.
    set_btn(5'b00000);
    rst = 1'b1;
    pif.XPOS = 0;
    pif.YPOS = 480;
    @(negedge clk);
    rst = 1'b0;
    pif.XPOS = 1;
    pif.YPOS = 0;
    check_all("rst_mid", 240, 240, 320, 240, 0, 0, 0);

    // Nine rallies, each missed on the right with PADDLE2Y left at 240.
    // The serve direction in y alternates because dy survives a miss.
    // START is held through the first rally and must be ignored.
    for (int r = 1; r <= 9; r++) begin
      int d0;
      d0 = (r % 2 == 1) ? 2 : -2;
      set_btn((r == 1) ? 5'b00001 : 5'b00000);
      repeat (60) do_tick();
      check_all($sformatf("r%0d.serve", r), 240, 240, 320, 240, r - 1, 0, 0);
      do_tick();
      check_all($sformatf("r%0d.t1", r), 240, 240, 322, 240 + d0, r - 1, 0, 0);
      repeat (155) do_tick();
      check_all($sformatf("r%0d.t156", r), 240, 240, 632,
                (d0 > 0) ? 395 : 82, r - 1, 0, 0);
      do_tick();
      check_all($sformatf("r%0d.miss", r), 240, 240, 320, 240, r, 0,
                (r == 9) ? 1 : 0);
    end

    // Game over: everything frozen while paddle buttons toggle.
    for (int i = 0; i < 100; i++) begin
      set_btn((i % 2 == 1) ? 5'b10010 : 5'b01100);
      do_tick();
      check($sformatf("frz%0d.p1", i), pif.PADDLE1Y, 240);
      check($sformatf("frz%0d.p2", i), pif.PADDLE2Y, 240);
      check($sformatf("frz%0d.bx", i), pif.BALLX, 320);
      check($sformatf("frz%0d.go", i), 32'(pif.GAME_OVER), 1);
    end
    check_all("frz_end", 240, 240, 320, 240, 9, 0, 1);

    // START restarts: scores cleared, new serve of 60 frames, then the ball
    // leaves with dx=+2 and the dy=-2 kept from the last miss.
    set_btn(5'b00001);
    do_tick();
    check_all("restart", 240, 240, 320, 240, 0, 0, 0);
    set_btn(5'b00000);
    repeat (60) do_tick();
    check_all("restart.serve", 240, 240, 320, 240, 0, 0, 0);
    do_tick();
    check_all("restart.t1", 240, 240, 322, 238, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
